// File: rtl/temporal_buffer_mc_if.sv
// Write/read/status bundle for the multi-channel temporal literal buffer.
// The master drives the requests; the slave (the buffer) drives the responses.
interface temporal_buffer_mc_if #(
    parameter int NSAT = 3,
    parameter int LAW  = 12,
    parameter int SIZE = 2,
    parameter int NCH  = 4
);
    localparam int IW    = $clog2(NSAT);
    localparam int CW    = $clog2(NSAT + 1);
    localparam int ROW_W = NCH * SIZE * LAW;

    // Requests are single-cycle strobes; there is no backpressure.
    // rd_en_i in cycle N is answered by rd_valid_o in cycle N+1.
    logic             clear_i;
    logic             wr_en_i;
    logic [IW-1:0]    wr_index_i;
    logic [NCH-1:0]   wr_mask_i;
    logic [ROW_W-1:0] wr_literals_i;
    logic             rd_en_i;
    logic [IW-1:0]    rd_index_i;
    logic             rd_valid_o;
    logic             rd_err_o;
    logic [ROW_W-1:0] literals_o;
    logic [NCH-1:0]   ch_valid_o;
    logic [CW-1:0]    rows_written_o;
    logic             all_written_o;

    modport master (
        output clear_i, wr_en_i, wr_index_i, wr_mask_i, wr_literals_i,
        output rd_en_i, rd_index_i,
        input  rd_valid_o, rd_err_o, literals_o, ch_valid_o,
        input  rows_written_o, all_written_o
    );

    modport slave (
        input  clear_i, wr_en_i, wr_index_i, wr_mask_i, wr_literals_i,
        input  rd_en_i, rd_index_i,
        output rd_valid_o, rd_err_o, literals_o, ch_valid_o,
        output rows_written_o, all_written_o
    );
endinterface

// File: rtl/temporal_buffer_mc.sv
// Per-flip store of NCH clause literal groups with per-channel valid bits,
// same-cycle read forwarding, bulk clear and occupancy status.
module temporal_buffer_mc #(
    parameter int NSAT = 3,
    parameter int LAW  = 12,
    parameter int SIZE = 2,
    parameter int NCH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    temporal_buffer_mc_if.slave   bus
);
    localparam int          IW     = $clog2(NSAT);
    localparam int          CW     = $clog2(NSAT + 1);
    localparam int          CH_W   = SIZE * LAW;
    localparam int          ROW_W  = NCH * CH_W;
    localparam logic [31:0] NSAT_U = NSAT;

    logic [ROW_W-1:0] data_q  [NSAT];
    logic [ROW_W-1:0] data_d  [NSAT];
    logic [NCH-1:0]   valid_q [NSAT];
    logic [NCH-1:0]   valid_d [NSAT];

    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic [ROW_W-1:0] literals_q, literals_d;
    logic [NCH-1:0]   ch_valid_q, ch_valid_d;
    logic [CW-1:0]    rows_written_q, rows_written_d;
    logic             all_written_q, all_written_d;

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = (32'(bus.wr_index_i) < NSAT_U);
    assign rd_in_range = (32'(bus.rd_index_i) < NSAT_U);

    // Clear drops valid bits first so a same-cycle write re-validates its channels.
    always_comb begin
        for (int r = 0; r < NSAT; r++) begin
            data_d[r]  = data_q[r];
            valid_d[r] = bus.clear_i ? '0 : valid_q[r];
        end
        if (bus.wr_en_i && wr_in_range) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.wr_mask_i[c]) begin
                    data_d[bus.wr_index_i][c*CH_W +: CH_W] = bus.wr_literals_i[c*CH_W +: CH_W];
                    valid_d[bus.wr_index_i][c] = 1'b1;
                end
            end
        end
    end

    // Reading the post-update row gives forwarding for any index and any mask.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_err_d   = rd_err_q;
        literals_d = literals_q;
        ch_valid_d = ch_valid_q;
        if (bus.rd_en_i) begin
            rd_valid_d = 1'b1;
            if (rd_in_range) begin
                rd_err_d   = 1'b0;
                literals_d = data_d[bus.rd_index_i];
                ch_valid_d = valid_d[bus.rd_index_i];
            end else begin
                rd_err_d   = 1'b1;
                literals_d = '0;
                ch_valid_d = '0;
            end
        end
    end

    always_comb begin
        rows_written_d = '0;
        for (int r = 0; r < NSAT; r++) begin
            if (|valid_d[r]) rows_written_d = rows_written_d + CW'(1);
        end
        all_written_d = (rows_written_d == CW'(NSAT));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NSAT; r++) begin
                data_q[r]  <= '0;
                valid_q[r] <= '0;
            end
            rd_valid_q     <= 1'b0;
            rd_err_q       <= 1'b0;
            literals_q     <= '0;
            ch_valid_q     <= '0;
            rows_written_q <= '0;
            all_written_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NSAT; r++) begin
                data_q[r]  <= data_d[r];
                valid_q[r] <= valid_d[r];
            end
            rd_valid_q     <= rd_valid_d;
            rd_err_q       <= rd_err_d;
            literals_q     <= literals_d;
            ch_valid_q     <= ch_valid_d;
            rows_written_q <= rows_written_d;
            all_written_q  <= all_written_d;
        end
    end

    assign bus.rd_valid_o     = rd_valid_q;
    assign bus.rd_err_o       = rd_err_q;
    assign bus.literals_o     = literals_q;
    assign bus.ch_valid_o     = ch_valid_q;
    assign bus.rows_written_o = rows_written_q;
    assign bus.all_written_o  = all_written_q;

    logic unused_iw;
    assign unused_iw = (IW == 0);
endmodule

// File: tb/tb_temporal_buffer_mc.sv
// Directed bench for temporal_buffer_mc at NSAT=3, NCH=4, SIZE=2, LAW=12.
module tb_temporal_buffer_mc;
    localparam int NSAT = 3;
    localparam int LAW  = 12;
    localparam int SIZE = 2;
    localparam int NCH  = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    temporal_buffer_mc_if #(.NSAT(NSAT), .LAW(LAW), .SIZE(SIZE), .NCH(NCH)) bus ();

    temporal_buffer_mc #(.NSAT(NSAT), .LAW(LAW), .SIZE(SIZE), .NCH(NCH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row patterns, channel 3 in the top 24 bits.
    logic [95:0] d_tab [3];
    initial begin
        d_tab[0] = 96'h0A0B0C_0D0E0F_010203_040506;
        d_tab[1] = 96'hAAAAAA_BBBBBB_CCCCCC_DDDDDD;
        d_tab[2] = 96'h123456_789ABC_DEF012_345678;
    end

    task automatic idle();
        bus.clear_i       = 1'b0;
        bus.wr_en_i       = 1'b0;
        bus.wr_index_i    = '0;
        bus.wr_mask_i     = '0;
        bus.wr_literals_i = '0;
        bus.rd_en_i       = 1'b0;
        bus.rd_index_i    = '0;
    endtask

    // Apply the current inputs across one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] idx);
        idle();
        bus.rd_en_i    = 1'b1;
        bus.rd_index_i = idx;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.rd_valid_o !== 1'b0 || bus.literals_o !== 96'h0 || bus.ch_valid_o !== 4'h0 ||
            bus.rows_written_o !== 2'd0 || bus.all_written_o !== 1'b0 || bus.rd_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rv=%b lit=%h cv=%b rows=%0d all=%b err=%b required all zero",
                     bus.rd_valid_o, bus.literals_o, bus.ch_valid_o, bus.rows_written_o,
                     bus.all_written_o, bus.rd_err_o);
        end
        rst = 1'b0;
        do_read(2'd1);
        checks++;
        if (bus.rd_valid_o !== 1'b1 || bus.literals_o !== 96'h0 || bus.ch_valid_o !== 4'b0000 ||
            bus.rows_written_o !== 2'd0 || bus.rd_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_read: rv=%b lit=%h cv=%b rows=%0d err=%b required rv=1 lit=0 cv=0 rows=0 err=0",
                     bus.rd_valid_o, bus.literals_o, bus.ch_valid_o, bus.rows_written_o, bus.rd_err_o);
        end
        step();
        checks++;
        if (bus.rd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL read_strobe_one_cycle: rv=%b required 0", bus.rd_valid_o);
        end
    endtask

    task automatic test_masked_write();
        idle();
        bus.wr_en_i       = 1'b1;
        bus.wr_index_i    = 2'd0;
        bus.wr_mask_i     = 4'b0101;
        bus.wr_literals_i = {24'hEEEEEE, 24'h123456, 24'hDDDDDD, 24'h00A00B};
        step();
        idle();
        checks++;
        if (bus.rows_written_o !== 2'd1 || bus.all_written_o !== 1'b0) begin
            failures++;
            $display("FAIL masked_rows: rows=%0d all=%b required rows=1 all=0",
                     bus.rows_written_o, bus.all_written_o);
        end
        step();
        do_read(2'd0);
        checks++;
        if (bus.ch_valid_o !== 4'b0101 ||
            bus.literals_o !== {24'h000000, 24'h123456, 24'h000000, 24'h00A00B}) begin
            failures++;
            $display("FAIL masked_read: cv=%b lit=%h required cv=0101 lit=%h", bus.ch_valid_o,
                     bus.literals_o, {24'h000000, 24'h123456, 24'h000000, 24'h00A00B});
        end
        step();
        checks++;
        if (bus.rd_valid_o !== 1'b0 || bus.ch_valid_o !== 4'b0101 ||
            bus.literals_o !== {24'h000000, 24'h123456, 24'h000000, 24'h00A00B}) begin
            failures++;
            $display("FAIL hold_outputs: rv=%b cv=%b lit=%h required rv=0 and held row",
                     bus.rd_valid_o, bus.ch_valid_o, bus.literals_o);
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.wr_en_i       = 1'b1;
            bus.wr_index_i    = 2'(i);
            bus.wr_mask_i     = 4'b1111;
            bus.wr_literals_i = d_tab[i];
            bus.rd_en_i       = 1'b1;
            bus.rd_index_i    = 2'(i);
            step();
            idle();
            checks++;
            if (bus.rd_valid_o !== 1'b1 || bus.literals_o !== d_tab[i] || bus.ch_valid_o !== 4'b1111) begin
                failures++;
                $display("FAIL forward_idx%0d: rv=%b lit=%h cv=%b required rv=1 lit=%h cv=1111",
                         i, bus.rd_valid_o, bus.literals_o, bus.ch_valid_o, d_tab[i]);
            end
        end
        checks++;
        if (bus.rows_written_o !== 2'd3 || bus.all_written_o !== 1'b1) begin
            failures++;
            $display("FAIL fill_status: rows=%0d all=%b required rows=3 all=1",
                     bus.rows_written_o, bus.all_written_o);
        end
    endtask

    task automatic test_partial_forward();
        idle();
        bus.wr_en_i       = 1'b1;
        bus.wr_index_i    = 2'd2;
        bus.wr_mask_i     = 4'b0010;
        bus.wr_literals_i = 96'hFFFFFF_FFFFFF_5A5A5A_FFFFFF;
        bus.rd_en_i       = 1'b1;
        bus.rd_index_i    = 2'd2;
        step();
        idle();
        checks++;
        if (bus.literals_o !== 96'h123456_789ABC_5A5A5A_345678 || bus.ch_valid_o !== 4'b1111) begin
            failures++;
            $display("FAIL partial_forward: lit=%h cv=%b required lit=123456789abc5a5a5a345678 cv=1111",
                     bus.literals_o, bus.ch_valid_o);
        end
        checks++;
        if (bus.rows_written_o !== 2'd3) begin
            failures++;
            $display("FAIL rewrite_no_increment: rows=%0d required 3", bus.rows_written_o);
        end
    endtask

    task automatic test_clear();
        idle();
        bus.clear_i       = 1'b1;
        bus.wr_en_i       = 1'b1;
        bus.wr_index_i    = 2'd1;
        bus.wr_mask_i     = 4'b0001;
        bus.wr_literals_i = 96'h999999_888888_777777_C0FFEE;
        step();
        idle();
        checks++;
        if (bus.rows_written_o !== 2'd1 || bus.all_written_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_write_rows: rows=%0d all=%b required rows=1 all=0",
                     bus.rows_written_o, bus.all_written_o);
        end
        do_read(2'd0);
        checks++;
        if (bus.ch_valid_o !== 4'b0000 || bus.literals_o !== d_tab[0]) begin
            failures++;
            $display("FAIL clear_read_idx0: cv=%b lit=%h required cv=0000 lit=%h (stale)",
                     bus.ch_valid_o, bus.literals_o, d_tab[0]);
        end
        do_read(2'd1);
        checks++;
        if (bus.ch_valid_o !== 4'b0001 || bus.literals_o !== 96'hAAAAAA_BBBBBB_CCCCCC_C0FFEE) begin
            failures++;
            $display("FAIL clear_read_idx1: cv=%b lit=%h required cv=0001 lit=aaaaaabbbbbbccccccc0ffee",
                     bus.ch_valid_o, bus.literals_o);
        end
    endtask

    task automatic test_out_of_range();
        idle();
        bus.wr_en_i       = 1'b1;
        bus.wr_index_i    = 2'd3;
        bus.wr_mask_i     = 4'b1111;
        bus.wr_literals_i = 96'h555555_555555_555555_555555;
        step();
        idle();
        checks++;
        if (bus.rows_written_o !== 2'd1) begin
            failures++;
            $display("FAIL oor_write_rows: rows=%0d required 1", bus.rows_written_o);
        end
        do_read(2'd3);
        checks++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_err_o !== 1'b1 || bus.literals_o !== 96'h0 ||
            bus.ch_valid_o !== 4'b0000) begin
            failures++;
            $display("FAIL oor_read: rv=%b err=%b lit=%h cv=%b required rv=1 err=1 lit=0 cv=0000",
                     bus.rd_valid_o, bus.rd_err_o, bus.literals_o, bus.ch_valid_o);
        end
        step();
        checks++;
        if (bus.rd_err_o !== 1'b1 || bus.rd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL err_hold: err=%b rv=%b required err=1 rv=0", bus.rd_err_o, bus.rd_valid_o);
        end
        do_read(2'd0);
        checks++;
        if (bus.rd_err_o !== 1'b0 || bus.ch_valid_o !== 4'b0000 || bus.literals_o !== d_tab[0]) begin
            failures++;
            $display("FAIL after_oor_idx0: err=%b cv=%b lit=%h required err=0 cv=0000 lit=%h",
                     bus.rd_err_o, bus.ch_valid_o, bus.literals_o, d_tab[0]);
        end
        do_read(2'd1);
        checks++;
        if (bus.ch_valid_o !== 4'b0001 || bus.literals_o !== 96'hAAAAAA_BBBBBB_CCCCCC_C0FFEE) begin
            failures++;
            $display("FAIL oor_no_side_effect: cv=%b lit=%h required cv=0001 lit=aaaaaabbbbbbccccccc0ffee",
                     bus.ch_valid_o, bus.literals_o);
        end
    endtask

    task automatic test_clear_alone();
        idle();
        bus.clear_i = 1'b1;
        step();
        idle();
        checks++;
        if (bus.rows_written_o !== 2'd0 || bus.all_written_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_alone_rows: rows=%0d all=%b required 0 0",
                     bus.rows_written_o, bus.all_written_o);
        end
    endtask

    task automatic test_reset_mid_read();
        idle();
        bus.wr_en_i       = 1'b1;
        bus.wr_index_i    = 2'd2;
        bus.wr_mask_i     = 4'b1111;
        bus.wr_literals_i = d_tab[2];
        step();
        idle();
        bus.rd_en_i    = 1'b1;
        bus.rd_index_i = 2'd2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        checks++;
        if (bus.rd_valid_o !== 1'b0 || bus.literals_o !== 96'h0 || bus.ch_valid_o !== 4'h0 ||
            bus.rows_written_o !== 2'd0 || bus.all_written_o !== 1'b0 || bus.rd_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read: rv=%b lit=%h cv=%b rows=%0d all=%b err=%b required all zero",
                     bus.rd_valid_o, bus.literals_o, bus.ch_valid_o, bus.rows_written_o,
                     bus.all_written_o, bus.rd_err_o);
        end
        do_read(2'd2);
        checks++;
        if (bus.literals_o !== 96'h0 || bus.ch_valid_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_clears_data: lit=%h cv=%b required 0 0", bus.literals_o, bus.ch_valid_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_masked_write();
        test_forward();
        test_partial_forward();
        test_clear();
        test_out_of_range();
        test_clear_alone();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
